// File: rtl/branch_sequencer.sv
// branch_sequencer: conditional-branch initiator for the Mini SRC datapath.
// Owns the program counter, strobes the condition flip-flop (con_in), samples
// its registered decision and retires the branch by conditionally adding the
// sign-extended displacement to PC. Also serves PC increment and absolute load.
// Optional feature macro: BRANCH_STATS_EN adds saturating taken/not-taken
// counters (stat_taken, stat_not_taken).
module branch_sequencer #(
    parameter int PC_WIDTH  = 32,
    parameter int OFF_WIDTH = 19
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 br_start,
    input  logic [OFF_WIDTH-1:0] br_offset,
    input  logic                 con_branch,
    input  logic                 pc_inc,
    input  logic                 pc_load,
    input  logic [PC_WIDTH-1:0]  pc_din,
    output logic                 con_in,
    output logic [PC_WIDTH-1:0]  pc_out,
    output logic                 busy,
    output logic                 br_done,
    output logic                 br_taken
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]          stat_taken,
    output logic [15:0]          stat_not_taken
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        SETTLE = 2'd2,
        UPDATE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [OFF_WIDTH-1:0]  off_q, off_d;
    logic                  con_in_q, con_in_d;
    logic                  br_done_q, br_done_d;
    logic                  br_taken_q, br_taken_d;
    logic [PC_WIDTH-1:0]   off_sext;

    // Displacement widened to PC width with its sign bit replicated.
    assign off_sext = {{(PC_WIDTH-OFF_WIDTH){off_q[OFF_WIDTH-1]}}, off_q};

    // Next-state, PC and registered-output logic; an absolute load overrides all.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        off_d      = off_q;
        con_in_d   = 1'b0;
        br_done_d  = 1'b0;
        br_taken_d = br_taken_q;
        case (state_q)
            IDLE: begin
                // Increment and branch start may coexist; the offset is then
                // added to the already-incremented PC.
                if (pc_inc) begin
                    pc_d = pc_q + PC_WIDTH'(1);
                end
                if (br_start) begin
                    state_d  = STROBE;
                    off_d    = br_offset;
                    con_in_d = 1'b1;
                end
            end
            STROBE: begin
                state_d = SETTLE;
            end
            SETTLE: begin
                // Decision is captured here so br_done/br_taken are registered
                // and visible together during the UPDATE cycle.
                state_d    = UPDATE;
                br_done_d  = 1'b1;
                br_taken_d = con_branch;
            end
            UPDATE: begin
                state_d = IDLE;
                if (br_taken_q) begin
                    pc_d = pc_q + off_sext;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Load has top priority; outside IDLE it also aborts the sequence.
        if (pc_load) begin
            pc_d       = pc_din;
            state_d    = IDLE;
            con_in_d   = 1'b0;
            br_done_d  = 1'b0;
            br_taken_d = br_taken_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            off_q      <= '0;
            con_in_q   <= 1'b0;
            br_done_q  <= 1'b0;
            br_taken_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            off_q      <= off_d;
            con_in_q   <= con_in_d;
            br_done_q  <= br_done_d;
            br_taken_q <= br_taken_d;
        end
    end

    assign con_in   = con_in_q;
    assign pc_out   = pc_q;
    assign busy     = (state_q != IDLE);
    assign br_done  = br_done_q;
    assign br_taken = br_taken_q;

`ifdef BRANCH_STATS_EN
    // Index 0 counts not-taken retirements, index 1 counts taken ones.
    logic [15:0] stat_q [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stat
            // Saturating retirement counter for one branch outcome.
            always_ff @(posedge clock) begin
                if (reset) begin
                    stat_q[gi] <= 16'h0000;
                end else if (br_done_q && (br_taken_q == 1'(gi)) &&
                             (stat_q[gi] != 16'hFFFF)) begin
                    stat_q[gi] <= stat_q[gi] + 16'h0001;
                end
            end
        end
    endgenerate

    assign stat_not_taken = stat_q[0];
    assign stat_taken     = stat_q[1];
`endif

endmodule
